logic_unit_scheduler: RTL and testbench

- Shares one bank of 64-bit 7-stage logic units (and_64, or_64, xor_64) among the four cores of the quad-core processor.
- Round-robin arbitrates core requests and issues at most one operation per cycle into the shared operand register feeding all three units.
- Carries a tag/op/valid shadow pipeline matched to the unit latency, because the units have no valid signal.
- Returns the selected result to the issuing core.

---
 rtl/logic_unit_scheduler_pkg.sv | 25 ++
 rtl/rr_arb4.sv | 47 ++++
 rtl/logic_unit_scheduler.sv | 122 ++++++++++++
 tb/tb_logic_unit_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_scheduler_pkg.sv
// Shared definitions for the quad-core logic-unit scheduler.
// Holds the geometry constants, the op encoding and the shadow-stage payload.
package logic_unit_scheduler_pkg;

   localparam int unsigned W     = 64;  // operand / result width
   localparam int unsigned LAT   = 7;   // unit latency, also shadow pipeline depth
   localparam int unsigned NCORE = 4;   // requesting cores
   localparam int unsigned TAG_W = 2;   // core tag width
   localparam int unsigned CNT_W = 4;   // in-flight counter width (0..LAT)

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   // One shadow stage travelling alongside the data in the logic units.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      op_e              op;
   } shadow_t;

endpackage

// File: rtl/rr_arb4.sv
// Four-input round-robin arbiter.
// Ports: clk, rst (sync, active high), en (grant enable), req[3:0] requests,
//        gnt[3:0] one-hot combinational grant. The pointer moves to the core
//        after the granted one on every grant edge and holds otherwise.
module rr_arb4
   import logic_unit_scheduler_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NCORE-1:0] req,
   output logic [NCORE-1:0] gnt
);

   logic [TAG_W-1:0] rr_q;
   logic [TAG_W-1:0] rr_d;
   logic [TAG_W-1:0] idx;
   logic             found;

   // Search rr, rr+1, ... (mod 4); the 2-bit index wraps naturally.
   always_comb begin
      gnt   = '0;
      rr_d  = rr_q;
      idx   = '0;
      found = 1'b0;
      if (en && !rst) begin
         for (int unsigned k = 0; k < NCORE; k++) begin
            idx = TAG_W'(rr_q + TAG_W'(k));
            if (!found && req[idx]) begin
               found    = 1'b1;
               gnt[idx] = 1'b1;
               rr_d     = TAG_W'(idx + TAG_W'(1));
            end
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/logic_unit_scheduler.sv
// Shares one bank of 64-bit logic units (and/or/xor) among four cores.
// Ports: clk, rst (sync, active high); issue_en gates new grants;
//        req/op/a/b per-core request, op code and operands (packed by core);
//        gnt one-hot combinational grant; unit_a/unit_b registered operands
//        to the units; res_and/res_or/res_xor unit outputs; rsp_valid/rsp_data
//        one-hot response and result; inflight count of live shadow stages;
//        idle when nothing is in flight and nothing is requested.
module logic_unit_scheduler
   import logic_unit_scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_en,
   input  logic [NCORE-1:0]     req,
   input  logic [2*NCORE-1:0]   op,
   input  logic [NCORE*W-1:0]   a,
   input  logic [NCORE*W-1:0]   b,
   output logic [NCORE-1:0]     gnt,
   output logic [W-1:0]         unit_a,
   output logic [W-1:0]         unit_b,
   input  logic [W-1:0]         res_and,
   input  logic [W-1:0]         res_or,
   input  logic [W-1:0]         res_xor,
   output logic [NCORE-1:0]     rsp_valid,
   output logic [W-1:0]         rsp_data,
   output logic [CNT_W-1:0]     inflight,
   output logic                 idle
);

   logic [W-1:0]          unit_a_q, unit_a_d;
   logic [W-1:0]          unit_b_q, unit_b_d;
   shadow_t [LAT-1:0]     shadow_q, shadow_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;

   logic [TAG_W-1:0]      sel_tag;
   logic [W-1:0]          sel_a;
   logic [W-1:0]          sel_b;
   op_e                   sel_op;
   shadow_t               last;

   rr_arb4 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (issue_en),
      .req (req),
      .gnt (gnt)
   );

   // One-hot select of the granted core's operands and op.
   always_comb begin
      sel_tag = '0;
      sel_a   = '0;
      sel_b   = '0;
      sel_op  = OP_AND;
      for (int unsigned k = 0; k < NCORE; k++) begin
         if (gnt[k]) begin
            sel_tag = TAG_W'(k);
            sel_a   = a[k*W +: W];
            sel_b   = b[k*W +: W];
            sel_op  = op_e'(op[2*k +: 2]);
         end
      end
   end

   // Next state: operands load only on a grant; the shadow pipe always shifts.
   always_comb begin
      unit_a_d = unit_a_q;
      unit_b_d = unit_b_q;
      shadow_d = '0;
      inflight_d = '0;
      if (|gnt) begin
         unit_a_d = sel_a;
         unit_b_d = sel_b;
      end
      shadow_d[0].valid = |gnt;
      shadow_d[0].tag   = sel_tag;
      shadow_d[0].op    = sel_op;
      for (int unsigned k = 1; k < LAT; k++) begin
         shadow_d[k] = shadow_q[k-1];
      end
      for (int unsigned k = 0; k < LAT; k++) begin
         inflight_d = CNT_W'(inflight_d + CNT_W'(shadow_d[k].valid));
      end
   end

   // State registers; reset drops every in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         unit_a_q   <= '0;
         unit_b_q   <= '0;
         shadow_q   <= '0;
         inflight_q <= '0;
      end else begin
         unit_a_q   <= unit_a_d;
         unit_b_q   <= unit_b_d;
         shadow_q   <= shadow_d;
         inflight_q <= inflight_d;
      end
   end

   // Response decode from the last shadow stage, aligned with the unit outputs.
   always_comb begin
      last      = shadow_q[LAT-1];
      rsp_valid = '0;
      rsp_data  = '0;
      if (last.valid) begin
         rsp_valid[last.tag] = 1'b1;
         case (last.op)
            OP_AND:  rsp_data = res_and;
            OP_OR:   rsp_data = res_or;
            OP_XOR:  rsp_data = res_xor;
            default: rsp_data = ~res_or;
         endcase
      end
   end

   assign unit_a   = unit_a_q;
   assign unit_b   = unit_b_q;
   assign inflight = inflight_q;
   assign idle     = (inflight_q == '0) && (req == '0);

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Randomised scoreboard bench for logic_unit_scheduler.
module tb_logic_unit_scheduler;
   import logic_unit_scheduler_pkg::*;

   localparam int LATI = int'(LAT);

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         issue_en = 1'b0;
   logic [3:0]   req = '0;
   logic [7:0]   op = '0;
   logic [255:0] a = '0;
   logic [255:0] b = '0;
   logic [3:0]   gnt;
   logic [63:0]  unit_a, unit_b;
   logic [63:0]  res_and, res_or, res_xor;
   logic [3:0]   rsp_valid;
   logic [63:0]  rsp_data;
   logic [3:0]   inflight;
   logic         idle;

   logic_unit_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .issue_en  (issue_en),
      .req       (req),
      .op        (op),
      .a         (a),
      .b         (b),
      .gnt       (gnt),
      .unit_a    (unit_a),
      .unit_b    (unit_b),
      .res_and   (res_and),
      .res_or    (res_or),
      .res_xor   (res_xor),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .inflight  (inflight),
      .idle      (idle)
   );

   // Behavioural logic units: operands delayed so results land LAT-1 edges
   // after the operand register loads.
   logic [63:0] dly_a [LAT-1];
   logic [63:0] dly_b [LAT-1];
   always @(posedge clk) begin
      dly_a[0] <= unit_a;
      dly_b[0] <= unit_b;
      for (int k = 1; k < LATI - 1; k++) begin
         dly_a[k] <= dly_a[k-1];
         dly_b[k] <= dly_b[k-1];
      end
   end
   assign res_and = dly_a[LAT-2] & dly_b[LAT-2];
   assign res_or  = dly_a[LAT-2] | dly_b[LAT-2];
   assign res_xor = dly_a[LAT-2] ^ dly_b[LAT-2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          tag;
      logic [63:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   bit          pend [4];
   logic [1:0]  p_op [4];
   logic [63:0] p_a  [4];
   logic [63:0] p_b  [4];
   bit          n_rst = 1'b1;
   bit          n_en  = 1'b1;
   int          rr_m  = 0;
   logic [3:0]  exp_gnt = '0;
   bit          mon_en  = 1'b0;
   bit          tb_done = 1'b0;
   int          checks = 0;
   int          failures = 0;

   function automatic logic [63:0] ref_op(logic [1:0] o, logic [63:0] x, logic [63:0] y);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x | y);
      endcase
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One request cycle: drive staged inputs, predict grant, queue the response.
   task automatic step();
      exp_t keep[$];
      @(posedge clk);
      #1;
      if (rst) begin
         foreach (sb[i]) if (sb[i].due < cyc) keep.push_back(sb[i]);
         sb   = keep;
         rr_m = 0;
      end
      rst      = n_rst;
      issue_en = n_en;
      for (int i = 0; i < 4; i++) begin
         req[i]         = pend[i];
         op[2*i +: 2]   = p_op[i];
         a[64*i +: 64]  = p_a[i];
         b[64*i +: 64]  = p_b[i];
      end
      exp_gnt = '0;
      if (issue_en && !rst && req != 4'b0) begin
         for (int s = 0; s < 4; s++) begin
            int k;
            k = (rr_m + s) % 4;
            if (req[k]) begin
               exp_gnt[k] = 1'b1;
               sb.push_back('{tag: k, data: ref_op(p_op[k], p_a[k], p_b[k]), due: cyc + LATI});
               rr_m    = (k + 1) % 4;
               pend[k] = 1'b0;
               break;
            end
         end
      end
   endtask

   task automatic raise(int c, logic [1:0] o, logic [63:0] x, logic [63:0] y);
      pend[c] = 1'b1;
      p_op[c] = o;
      p_a[c]  = x;
      p_b[c]  = y;
   endtask

   task automatic do_reset();
      n_rst = 1'b1;
      step();
      n_rst = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) step();
      step();
   endtask

   // Stimulus
   initial begin : driver
      for (int i = 0; i < 4; i++) begin
         p_op[i] = '0;
         p_a[i]  = '0;
         p_b[i]  = '0;
      end
      n_rst = 1'b1;
      step();
      step();
      n_rst = 1'b0;
      step();
      mon_en = 1'b1;

      // single request on core 2
      raise(2, 2'b01, 64'h1111111111111111, 64'h2222222222222222);
      step();
      drain();

      // all four cores continuously from rr=0
      do_reset();
      for (int n = 0; n < 12; n++) begin
         for (int c = 0; c < 4; c++)
            if (!pend[c]) raise(c, 2'($urandom_range(0, 3)), rnd64(), rnd64());
         step();
      end
      for (int c = 0; c < 4; c++) pend[c] = 1'b0;
      drain();

      // op coverage on core 1
      for (int o = 0; o < 4; o++) begin
         raise(1, 2'(o), 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00);
         step();
      end
      drain();

      // reset while three ops are in flight
      do_reset();
      for (int c = 0; c < 3; c++) raise(c, 2'(c), rnd64(), rnd64());
      repeat (3) step();
      repeat (2) step();
      do_reset();
      raise(1, 2'b10, rnd64(), rnd64());
      raise(3, 2'b00, rnd64(), rnd64());
      step();
      step();
      drain();

      // issue_en low while requests wait and four ops drain
      do_reset();
      for (int c = 0; c < 4; c++) raise(c, 2'($urandom_range(0, 3)), rnd64(), rnd64());
      repeat (4) step();
      raise(0, 2'b11, rnd64(), rnd64());
      raise(3, 2'b01, rnd64(), rnd64());
      n_en = 1'b0;
      repeat (10) step();
      n_en = 1'b1;
      repeat (2) step();
      drain();

      // core 3 requests for one cycle only, core 0 wins
      do_reset();
      raise(0, 2'b00, rnd64(), rnd64());
      raise(3, 2'b10, rnd64(), rnd64());
      step();
      pend[3] = 1'b0;
      drain();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < 4; c++) begin
            if (!pend[c]) begin
               if ($urandom_range(0, 2) == 0) raise(c, 2'($urandom_range(0, 3)), rnd64(), rnd64());
            end else if ($urandom_range(0, 15) == 0) begin
               pend[c] = 1'b0;
            end
         end
         n_en  = ($urandom_range(0, 7) != 0);
         n_rst = ($urandom_range(0, 127) == 0);
         step();
      end
      n_rst = 1'b0;
      n_en  = 1'b1;
      for (int c = 0; c < 4; c++) pend[c] = 1'b0;
      step();
      drain();
      tb_done = 1'b1;
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, expv);
      end
   endtask

   // Monitor: compares every cycle against the scoreboard.
   initial begin : monitor
      int          exp_inf;
      logic [3:0]  exp_rv;
      logic [63:0] exp_rd;
      while (!tb_done) begin
         @(negedge clk);
         if (mon_en) begin
            exp_inf = 0;
            foreach (sb[i])
               if (sb[i].due - LATI + 1 <= cyc && cyc <= sb[i].due) exp_inf++;
            chk("gnt", 64'(gnt), 64'(exp_gnt));
            chk("inflight", 64'(inflight), 64'(exp_inf));
            chk("idle", 64'(idle), 64'(exp_inf == 0 && req == 4'b0));
            exp_rv = '0;
            exp_rd = '0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               exp_rv[sb[0].tag] = 1'b1;
               exp_rd = sb[0].data;
               void'(sb.pop_front());
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("rsp_data", rsp_data, exp_rd);
         end
      end
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
